vme_lbus_ctrl: RTL
==================

// Module: vme_lbus_ctrl
// PURPOSE
//  FPGA-side sequencer for VME A32/D32 register access. Takes the CPLD strobes FRS/FWS and the register address FA,
//  and treats them as asynchronous. Runs one local-bus read or write cycle per VME strobe against the user register
//  bank, then returns FDTACK to the CPLD, which forwards it unchanged to VME DTACK. Covers 32 word registers
//  (Base+0x00..0x7C). VME bus error is not used: a missing ack still completes the cycle with default data.
// PARAMETERS
//  SYNC_STAGES   2            synchronizer depth on FRS/FWS (>=2)
//  SETTLE        1            extra cycles strobe must stay stable before the access (address/data settling)
//  TIMEOUT       64           cycles to wait for LB_ACK before forced completion (1..255)
//  TO_RDATA      32'hDEAD_BEEF read data returned on timeout
// PORTS
//  SYSCLK     in   1   system clock (on-board 32 MHz, via FSYSCLK)
//  RST        in   1   synchronous reset, active-high
//  FRS        in   1   read strobe from CPLD, active-high, async
//  FWS        in   1   write strobe from CPLD, active-high, async
//  FA         in   5   register word address from CPLD (VME A[6:2])
//  FD_IN      in   32  VME data bus, write direction
//  FD_OUT     out  32  VME data bus, read direction
//  FD_OE      out  1   read-data output enable, active-high
//  FDTACK     out  1   DTACK to CPLD, active-low
//  LB_ADDR    out  5   local-bus address
//  LB_WDATA   out  32  local-bus write data
//  LB_WE      out  1   write pulse, 1 cycle
//  LB_RE      out  1   read pulse, 1 cycle
//  LB_RDATA   in   32  read data, valid with LB_ACK
//  LB_ACK     in   1   access done, 1 cycle, any time from the cycle of LB_RE/LB_WE onward
//  TO_CNT     out  8   saturating count of timed-out accesses
// BEHAVIOUR
//  Reset values: FDTACK=1, FD_OE=0, FD_OUT=0, LB_WE=LB_RE=0, LB_ADDR=0, LB_WDATA=0, TO_CNT=0, state=HOLD.
//  rs/ws = synchronized FRS/FWS. FA and FD_IN are sampled only in SETUP, never synchronized.
//  FSM states:
//   HOLD   : entered from reset. Go to IDLE once rs=ws=0. A strobe live across reset is never served.
//   IDLE   : rs^ws=1 -> SETUP with cnt=SETTLE and dir latched. rs&ws=1 (illegal) -> stay in IDLE.
//   SETUP  : strobe drops -> IDLE (glitch, no access). cnt=0 -> latch LB_ADDR<=FA, LB_WDATA<=FD_IN -> ACCESS.
//            Otherwise cnt--.
//   ACCESS : first cycle pulses LB_WE or LB_RE; wait counter starts at 0.
//            LB_ACK (incl. same cycle as pulse) -> FD_OUT<=LB_RDATA on read -> DTACK.
//            Wait counter reaching TIMEOUT with no ack -> FD_OUT<=TO_RDATA on read, TO_CNT++ (saturates 255) -> DTACK.
//            An ACK arriving in the timeout cycle counts as ack, not timeout.
//   DTACK  : FDTACK=0; FD_OE=1 for reads. Remain until rs=ws=0, then FDTACK=1 and FD_OE=0 in the same cycle -> IDLE.
//  Strobe released during ACCESS (master abort): the local cycle still completes, and DTACK then releases
//   immediately since strobes are already low. The next strobe cannot start until IDLE.
//  Late LB_ACK (after timeout, in DTACK/IDLE) is ignored.
//  Latency: FRS edge -> LB_RE = SYNC_STAGES+SETTLE+1 cycles. LB_ACK -> FDTACK low = 1 cycle.
//   Strobe low -> FDTACK high = SYNC_STAGES+1 cycles.
//  RST mid-cycle: all outputs return to reset values the next edge. FDTACK rises even with the strobe still held.
//  FD_OUT holds its last value while FD_OE=0. LB_ADDR/LB_WDATA hold between accesses.
// STRUCTURE
//  Package vme_lbus_pkg: state encoding (HOLD,IDLE,SETUP,ACCESS,DTACK), FA_W=5, D_W=32, TO_W=8,
//   DTACK_ACT=1'b0.
//  Sub-module strobe_sync: SYNC_STAGES-deep 2-bit flop synchronizer, reset to 0. FSM, counters and datapath in top.
// TESTING
//  Write: FWS=1, FA=5'h03, FD_IN=32'h1234_5678, LB_ACK 2 cycles after LB_WE -> LB_ADDR=3, LB_WDATA=32'h1234_5678,
//   one LB_WE, FDTACK low until FWS low + 3 cycles.
//  Read: FRS=1, FA=5'h1F, LB_RDATA=32'hCAFE_0001 with ack same cycle as LB_RE -> FD_OUT=32'hCAFE_0001, FD_OE=1,
//   FDTACK=0; LB_RE at edge+4.
//  Timeout: FRS=1, no LB_ACK -> FDTACK low after 64 wait cycles, FD_OUT=32'hDEAD_BEEF, TO_CNT=1.
//   Repeat 300 times -> TO_CNT=255.
//  Glitch/illegal: FWS high 1 cycle -> no LB_WE, FDTACK stays 1. FRS=FWS=1 -> no local access.
//  Reset mid-op: assert RST in DTACK with FRS held -> FDTACK=1, FD_OE=0 next cycle, no new LB_RE until FRS drops and
//   rises again.
//  Back-to-back: 8 reads to FA=0..7 with 2-cycle strobe gaps -> 8 LB_RE pulses, addresses in order, one FDTACK per
//   strobe.

Source files
------------

// File: rtl/vme_lbus_pkg.sv
// Shared types and constants for the VME local-bus sequencer.
//   FA_W      : register word address width (VME A[6:2])
//   D_W       : data width of the VME and local buses
//   TO_W      : width of the timed-out access counter
//   DTACK_ACT : level of FDTACK while the cycle is acknowledged
//   state_e   : sequencer states
package vme_lbus_pkg;

  localparam int unsigned FA_W      = 5;
  localparam int unsigned D_W       = 32;
  localparam int unsigned TO_W      = 8;
  localparam logic        DTACK_ACT = 1'b0;

  typedef enum logic [2:0] {
    StHold,
    StIdle,
    StSetup,
    StAccess,
    StDtack
  } state_e;

endpackage

// File: rtl/strobe_sync.sv
// Multi-stage flop synchronizer for the two CPLD strobes (read, write).
//   clk_i    : system clock
//   rst_i    : synchronous reset, active-high; clears every stage to 0
//   strobe_i : {FRS, FWS} straight from the pins, asynchronous
//   strobe_o : {rs, ws} after SYNC_STAGES flops
module strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] strobe_i,
  output logic [1:0] strobe_o
);

  logic [SYNC_STAGES-1:0][1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_i};
    end
  end

  assign strobe_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/vme_lbus_ctrl.sv
// VME A32/D32 register-access sequencer: one local-bus read or write per CPLD strobe, then DTACK.
//   SYSCLK/RST        : clock, synchronous active-high reset
//   FRS/FWS           : read/write strobes from the CPLD (asynchronous)
//   FA/FD_IN          : register word address and write data, sampled at the end of the settle time
//   FD_OUT/FD_OE      : read data toward VME and its output enable
//   FDTACK            : DTACK to the CPLD, active-low
//   LB_ADDR/LB_WDATA  : local-bus address and write data, held between accesses
//   LB_WE/LB_RE       : one-cycle local-bus write/read pulses
//   LB_RDATA/LB_ACK   : local-bus read data and completion strobe
//   TO_CNT            : saturating count of accesses that ended on timeout
module vme_lbus_ctrl
  import vme_lbus_pkg::*;
#(
  parameter int unsigned    SYNC_STAGES = 2,
  parameter int unsigned    SETTLE      = 1,
  parameter int unsigned    TIMEOUT     = 64,
  parameter logic [D_W-1:0] TO_RDATA    = 32'hDEAD_BEEF
) (
  input  logic            SYSCLK,
  input  logic            RST,
  input  logic            FRS,
  input  logic            FWS,
  input  logic [FA_W-1:0] FA,
  input  logic [D_W-1:0]  FD_IN,
  output logic [D_W-1:0]  FD_OUT,
  output logic            FD_OE,
  output logic            FDTACK,
  output logic [FA_W-1:0] LB_ADDR,
  output logic [D_W-1:0]  LB_WDATA,
  output logic            LB_WE,
  output logic            LB_RE,
  input  logic [D_W-1:0]  LB_RDATA,
  input  logic            LB_ACK,
  output logic [TO_W-1:0] TO_CNT
);

  localparam int unsigned      CNT_W      = 8;
  localparam logic [CNT_W-1:0] HoldCnt    = CNT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] SettleCnt  = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  logic [1:0] strb_sync;
  logic       rs, ws;

  strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_strobe_sync (
    .clk_i    (SYSCLK),
    .rst_i    (RST),
    .strobe_i ({FRS, FWS}),
    .strobe_o (strb_sync)
  );

  assign rs = strb_sync[1];
  assign ws = strb_sync[0];

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_q, rd_d;
  logic [FA_W-1:0]  lb_addr_q, lb_addr_d;
  logic [D_W-1:0]   lb_wdata_q, lb_wdata_d;
  logic             lb_we_q, lb_we_d;
  logic             lb_re_q, lb_re_d;
  logic [D_W-1:0]   fd_out_q, fd_out_d;
  logic             fd_oe_q, fd_oe_d;
  logic             fdtack_q, fdtack_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    lb_addr_d  = lb_addr_q;
    lb_wdata_d = lb_wdata_q;
    lb_we_d    = 1'b0;
    lb_re_d    = 1'b0;
    fd_out_d   = fd_out_q;
    fd_oe_d    = fd_oe_q;
    fdtack_d   = fdtack_q;
    to_cnt_d   = to_cnt_q;

    unique case (state_q)
      // The synchronizer holds reset zeros for SYNC_STAGES cycles; wait them out so a strobe
      // held across reset is seen as busy and never served.
      StHold: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!rs && !ws) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (rs ^ ws) begin
          state_d = StSetup;
          cnt_d   = SettleCnt;
          rd_d    = rs;
        end
      end
      StSetup: begin
        if (!(rd_q ? rs : ws)) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          lb_addr_d  = FA;
          lb_wdata_d = FD_IN;
          lb_re_d    = rd_q;
          lb_we_d    = !rd_q;
          cnt_d      = '0;
          state_d    = StAccess;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // Strobes are ignored here: an aborted master still lets the local cycle finish.
      StAccess: begin
        if (LB_ACK || (cnt_q == TimeoutCnt)) begin
          state_d  = StDtack;
          fdtack_d = DTACK_ACT;
          fd_oe_d  = rd_q;
          if (LB_ACK) begin
            if (rd_q) fd_out_d = LB_RDATA;
          end else begin
            if (rd_q) fd_out_d = TO_RDATA;
            if (to_cnt_q != {TO_W{1'b1}}) to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDtack: begin
        if (!rs && !ws) begin
          fdtack_d = ~DTACK_ACT;
          fd_oe_d  = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state_q    <= StHold;
      cnt_q      <= HoldCnt;
      rd_q       <= 1'b0;
      lb_addr_q  <= '0;
      lb_wdata_q <= '0;
      lb_we_q    <= 1'b0;
      lb_re_q    <= 1'b0;
      fd_out_q   <= '0;
      fd_oe_q    <= 1'b0;
      fdtack_q   <= ~DTACK_ACT;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      lb_addr_q  <= lb_addr_d;
      lb_wdata_q <= lb_wdata_d;
      lb_we_q    <= lb_we_d;
      lb_re_q    <= lb_re_d;
      fd_out_q   <= fd_out_d;
      fd_oe_q    <= fd_oe_d;
      fdtack_q   <= fdtack_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign FD_OUT   = fd_out_q;
  assign FD_OE    = fd_oe_q;
  assign FDTACK   = fdtack_q;
  assign LB_ADDR  = lb_addr_q;
  assign LB_WDATA = lb_wdata_q;
  assign LB_WE    = lb_we_q;
  assign LB_RE    = lb_re_q;
  assign TO_CNT   = to_cnt_q;

endmodule
